colpar_collector: RTL and testbench

Receive-side counterpart to the column-parity datapath's serial bit writer. Consumes the serial theta-result bit stream: 25 bits per depth slice, 64 slices. Repacks each slice into a 25-bit word, using the same bit ordering the writer used. Hands each word to a downstream consumer (register file / next round stage) over a valid/ready handshake, and pulses done after the 64th slice.

---
 rtl/colpar_collector_pkg.sv | 21 ++
 rtl/colpar_collector_ctrl.sv | 75 +++++++
 rtl/colpar_collector.sv | 113 +++++++++++
 tb/tb_colpar_collector.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/colpar_collector_pkg.sv
// Shared constants and FSM encoding for the column-parity serial collector.
package colpar_collector_pkg;

  localparam int WIDTH = 25;  // lanes per depth slice
  localparam int DEPTH = 64;  // slices per frame
  localparam int CW    = 5;   // bit-counter width
  localparam int DW    = 6;   // depth-counter width

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Assembly bit position written by the bit with serial index cnt (first bit is MSB).
  function automatic int lane_of(input int cnt);
    return WIDTH - 1 - cnt;
  endfunction

endpackage

// File: rtl/colpar_collector_ctrl.sv
// Collector FSM: sequences IDLE/COLLECT/HOLD/DONE and decodes handshake strobes.
module colpar_collector_ctrl
  import colpar_collector_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_valid,
  input  logic word_ready,
  input  logic cnt_last,
  input  logic depth_last,
  output logic bit_ready,
  output logic word_valid,
  output logic busy,
  output logic done,
  output logic frame_start,
  output logic bit_accept,
  output logic word_accept
);

  state_t state_reg, state_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Handshake outputs depend on state only; the strobes are internal datapath enables.
  always_comb begin
    state_next  = state_reg;
    bit_ready   = 1'b0;
    word_valid  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    frame_start = 1'b0;
    bit_accept  = 1'b0;
    word_accept = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          frame_start = 1'b1;
          state_next  = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        bit_ready  = 1'b1;
        busy       = 1'b1;
        bit_accept = bit_valid;
        if (bit_valid && cnt_last) begin
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        word_valid  = 1'b1;
        busy        = 1'b1;
        word_accept = word_ready;
        if (word_ready) begin
          state_next = depth_last ? ST_DONE : ST_COLLECT;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        busy       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/colpar_collector.sv
// colpar_collector: repacks the serial theta-parity stream into 25-bit slice words
// and hands them downstream over a valid/ready handshake.
module colpar_collector
  import colpar_collector_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [WIDTH-1:0] word_out,
  output logic [DW-1:0]    word_depth,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             done
);

  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [DW-1:0]    depth_reg, depth_next;
  logic [WIDTH-1:0] asm_reg, asm_next, asm_fill;
  logic [WIDTH-1:0] word_out_reg, word_out_next;
  logic [DW-1:0]    word_depth_reg, word_depth_next;

  logic cnt_last, depth_last;
  logic cnt_init0, cnt_en, depth_init0, depth_en;
  logic frame_start, bit_accept, word_accept;

  assign cnt_last   = (cnt_reg == CW'(WIDTH - 1));
  assign depth_last = (depth_reg == DW'(DEPTH - 1));

  colpar_collector_ctrl u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bit_valid   (bit_valid),
    .word_ready  (word_ready),
    .cnt_last    (cnt_last),
    .depth_last  (depth_last),
    .bit_ready   (bit_ready),
    .word_valid  (word_valid),
    .busy        (busy),
    .done        (done),
    .frame_start (frame_start),
    .bit_accept  (bit_accept),
    .word_accept (word_accept)
  );

  // Each lane captures the bit whose serial index maps onto it; others hold.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      localparam logic [CW-1:0] LANE_CNT = CW'(lane_of(gi));
      assign asm_fill[gi] = (bit_accept && (cnt_reg == LANE_CNT)) ? bit_in : asm_reg[gi];
    end
  endgenerate

  assign cnt_init0   = frame_start | (bit_accept & cnt_last);
  assign cnt_en      = bit_accept;
  assign depth_init0 = frame_start | (word_accept & depth_last);
  assign depth_en    = word_accept;

  always_comb begin
    cnt_next        = cnt_reg;
    depth_next      = depth_reg;
    asm_next        = asm_fill;
    word_out_next   = word_out_reg;
    word_depth_next = word_depth_reg;

    if (cnt_init0) begin
      cnt_next = '0;
    end else if (cnt_en) begin
      cnt_next = cnt_reg + CW'(1);
    end

    if (depth_init0) begin
      depth_next = '0;
    end else if (depth_en) begin
      depth_next = depth_reg + DW'(1);
    end

    // A fresh slice starts from zero so unwritten lanes never leak old data.
    if (frame_start || word_accept) begin
      asm_next = '0;
    end

    if (bit_accept && cnt_last) begin
      word_out_next   = asm_fill;
      word_depth_next = depth_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg        <= '0;
      depth_reg      <= '0;
      asm_reg        <= '0;
      word_out_reg   <= '0;
      word_depth_reg <= '0;
    end else begin
      cnt_reg        <= cnt_next;
      depth_reg      <= depth_next;
      asm_reg        <= asm_next;
      word_out_reg   <= word_out_next;
      word_depth_reg <= word_depth_next;
    end
  end

  assign word_out   = word_out_reg;
  assign word_depth = word_depth_reg;

endmodule

// File: tb/tb_colpar_collector.sv
// Self-checking bench for colpar_collector: queue-based reference model plus directed/random frames.
module tb_colpar_collector;
  import colpar_collector_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             bit_in = 1'b0;
  logic             bit_valid = 1'b0;
  logic             word_ready = 1'b0;
  logic             bit_ready, word_valid, busy, done;
  logic [WIDTH-1:0] word_out;
  logic [DW-1:0]    word_depth;

  always #5 clk = ~clk;

  colpar_collector dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .word_out   (word_out),
    .word_depth (word_depth),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy),
    .done       (done)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of accepted bits grouped into slices.
  bit               m_in_frame, m_have_word, m_done_now;
  int               m_depth;
  bit               m_bits[$];
  logic [WIDTH-1:0] m_word_out, m_pack;
  logic [DW-1:0]    m_word_depth;

  always @(posedge clk) begin
    if (rst) begin
      m_in_frame = 0; m_have_word = 0; m_done_now = 0; m_depth = 0;
      m_bits.delete(); m_word_out = '0; m_word_depth = '0;
    end else if (m_done_now) begin
      m_done_now = 0;
    end else if (!m_in_frame) begin
      if (start) begin
        m_in_frame = 1; m_depth = 0; m_bits.delete();
      end
    end else if (m_have_word) begin
      if (word_ready) begin
        m_have_word = 0;
        if (m_depth == DEPTH - 1) begin
          m_in_frame = 0; m_done_now = 1;
        end else begin
          m_depth++;
        end
      end
    end else if (bit_valid) begin
      m_bits.push_back(bit_in);
      if (m_bits.size() == WIDTH) begin
        m_pack = '0;
        foreach (m_bits[k]) m_pack = {m_pack[WIDTH-2:0], m_bits[k]};
        m_word_out = m_pack; m_word_depth = DW'(m_depth); m_have_word = 1;
        m_bits.delete();
      end
    end
  end

  bit chk_en = 0;
  bit pattern_mode = 0;
  int exp_seq = 0, hs_count = 0, done_seen = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("bit_ready", {31'b0, bit_ready}, {31'b0, m_in_frame && !m_have_word});
      chk("word_valid", {31'b0, word_valid}, {31'b0, m_have_word});
      chk("busy", {31'b0, busy}, {31'b0, m_in_frame || m_done_now});
      chk("done", {31'b0, done}, {31'b0, m_done_now});
      chk("word_out", 32'(word_out), 32'(m_word_out));
      chk("word_depth", 32'(word_depth), 32'(m_word_depth));
      if (done) done_seen++;
      if (word_valid && word_ready && !rst) begin
        chk("word_seq", 32'(word_depth), 32'(exp_seq));
        if (pattern_mode) chk("word_pattern", 32'(word_out), 32'(word_depth));
        exp_seq++;
        hs_count++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int valid_mode = 0;  // 0: always valid, 1: toggling, 2: random
  bit gappy_tog = 1;
  bit wr_hold = 0;

  task automatic feed_bit(input bit b);
    bit acc;
    int guard;
    guard = 0;
    do begin
      case (valid_mode)
        0: bit_valid = 1'b1;
        1: begin bit_valid = gappy_tog; gappy_tog = ~gappy_tog; end
        default: bit_valid = 1'($urandom_range(0, 1));
      endcase
      bit_in = (valid_mode == 2 && !bit_valid) ? 1'($urandom_range(0, 1)) : b;
      word_ready = wr_hold;
      acc = bit_valid && bit_ready;
      step();
      guard++;
    end while (!acc && guard < 100);
    if (!acc) chk("bit_accept_timeout", 0, 1);
    bit_valid = 1'b0;
  endtask

  task automatic accept_word(input int delay, input logic [WIDTH-1:0] w, input int d);
    chk("word_valid_after_last_bit", {31'b0, word_valid}, 1);
    for (int k = 0; k < delay; k++) begin
      word_ready = 1'b0;
      bit_valid = 1'b1;
      bit_in = 1'($urandom_range(0, 1));
      chk("bp_bit_ready", {31'b0, bit_ready}, 0);
      chk("bp_word_out", 32'(word_out), 32'(w));
      chk("bp_word_depth", 32'(word_depth), 32'(d));
      step();
    end
    bit_valid = 1'b0;
    word_ready = 1'b1;
    step();
    word_ready = wr_hold;
  endtask

  task automatic run_frame(input bit random_data, input int bp_depth,
                           input bit start_mid, input bit rst_mid);
    logic [WIDTH-1:0] w;
    int delay;
    exp_seq = 0; hs_count = 0; done_seen = 0;
    pattern_mode = !random_data;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int d = 0; d < DEPTH; d++) begin
      w = random_data ? WIDTH'($urandom) : WIDTH'(d);
      for (int i = 0; i < WIDTH; i++) begin
        if (start_mid && d == 10 && i == 7) start = 1'b1;
        if (rst_mid && d == 30 && i == 12) begin
          rst = 1'b1; bit_valid = 1'b1;
          step();
          rst = 1'b0; bit_valid = 1'b0;
          chk("rst_busy", {31'b0, busy}, 0);
          chk("rst_word_valid", {31'b0, word_valid}, 0);
          chk("rst_word_out", 32'(word_out), 0);
          repeat (5) step();
          chk("rst_no_done", 32'(done_seen), 0);
          return;
        end
        feed_bit(w[WIDTH-1-i]);
        start = 1'b0;
      end
      if (d == bp_depth) delay = 10;
      else if (random_data) delay = $urandom_range(0, 3);
      else delay = 0;
      accept_word(delay, w, d);
    end
    repeat (3) step();
    chk("frame_done_pulses", 32'(done_seen), 1);
    chk("frame_words", 32'(hs_count), 64);
    chk("frame_last_depth_plus1", 32'(exp_seq), 64);
    chk("frame_idle_busy", {31'b0, busy}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    step();
    chk_en = 1;
    step();
    chk("reset_bit_ready", {31'b0, bit_ready}, 0);
    chk("reset_word_valid", {31'b0, word_valid}, 0);
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_done", {31'b0, done}, 0);
    chk("reset_word_out", 32'(word_out), 0);
    chk("reset_word_depth", 32'(word_depth), 0);
    rst = 1'b0;
    step();

    // Single slice 1,0,0,...: first bit lands in the MSB.
    valid_mode = 0; wr_hold = 0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - 1) chk("t1_valid_before_last", {31'b0, word_valid}, 0);
      feed_bit(i == 0);
    end
    chk("t1_word_valid", {31'b0, word_valid}, 1);
    chk("t1_word_out", 32'(word_out), 32'h0100_0000);
    chk("t1_word_depth", 32'(word_depth), 0);
    rst = 1'b1; step(); rst = 1'b0; step();

    // Full pattern frame, ready always high.
    valid_mode = 0; wr_hold = 1;
    run_frame(0, -1, 0, 0);

    // Backpressure of 10 cycles at slice 5.
    wr_hold = 0;
    run_frame(0, 5, 0, 0);

    // Gappy source with all-ones data.
    valid_mode = 1; gappy_tog = 1; wr_hold = 0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < WIDTH; i++) feed_bit(1'b1);
    chk("gappy_word_out", 32'(word_out), 32'h01FF_FFFF);
    chk("gappy_word_valid", {31'b0, word_valid}, 1);
    rst = 1'b1; step(); rst = 1'b0; step();

    // start mid-frame is ignored.
    valid_mode = 0; wr_hold = 1;
    run_frame(0, -1, 1, 0);

    // Reset mid-frame, then a fresh frame starts at depth 0.
    run_frame(0, -1, 0, 1);
    run_frame(0, -1, 0, 0);

    // Randomized traffic.
    for (int f = 0; f < 2; f++) begin
      valid_mode = 2;
      wr_hold = 1'($urandom_range(0, 1));
      run_frame(1, $urandom_range(0, DEPTH - 1), 0, 0);
    end

    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
